// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and constants for the SPI byte-transfer sequencer.
package spi_pkg;

    localparam int SPI_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD,
        DONE
    } spi_state_e;

    // Width of the phase counter: enough bits to hold the largest phase length.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Handshake and shift-register bus of the SPI transfer sequencer.
interface spi_xfer_ctrl_if;
    import spi_pkg::*;

    logic                tx_valid;
    logic                tx_ready;
    logic [SPI_BITS-1:0] tx_data;
    logic                rx_valid;
    logic [SPI_BITS-1:0] rx_data;
    logic                busy;
    logic                start;
    logic [SPI_BITS-1:0] load_data;
    logic [SPI_BITS-1:0] shift_data;
    logic                sclk;
    logic                cs_n;

    // Sequencer side.
    modport slave (
        input  tx_valid, tx_data, shift_data,
        output tx_ready, rx_valid, rx_data, busy, start, load_data, sclk, cs_n
    );

    // Byte producer / shift-register side.
    modport master (
        output tx_valid, tx_data, shift_data,
        input  tx_ready, rx_valid, rx_data, busy, start, load_data, sclk, cs_n
    );

endinterface

// File: rtl/spi_xfer_ctrl_clk_div.sv
// Phase counter: loaded with a phase length, flags the last cycle of the phase.
module spi_clk_div #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Counts down to zero; a phase of N cycles starts at N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI byte-transfer sequencer: loads the shift register, frames the byte with
// cs_n, generates 8 mode-0 SCLK periods and returns the received byte.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic           in_clock,
    input  logic           reset_n,
    spi_xfer_ctrl_if.slave bus
);

    localparam int CW = cnt_width(CLK_DIV, CS_SETUP, CS_HOLD);
    localparam int BW = $clog2(SPI_BITS);

    spi_state_e          state_q;
    logic [BW-1:0]       bit_cnt_q;
    logic                tx_ready_q;
    logic                rx_valid_q;
    logic                busy_q;
    logic                start_q;
    logic                sclk_q;
    logic                cs_n_q;
    logic [SPI_BITS-1:0] rx_data_q;
    logic [SPI_BITS-1:0] load_data_q;

    logic                div_load;
    logic [CW-1:0]       div_val;
    logic                div_done;

    // Reload the phase counter on every state change, with the next phase's length.
    always_comb begin
        div_load = 1'b0;
        div_val  = '0;
        case (state_q)
            LOAD: begin
                div_load = 1'b1;
                div_val  = CW'(CS_SETUP);
            end
            SETUP, SCLK_HI: begin
                div_load = div_done;
                div_val  = CW'(CLK_DIV);
            end
            SCLK_LO: begin
                div_load = div_done;
                div_val  = (bit_cnt_q == BW'(SPI_BITS - 1)) ? CW'(CS_HOLD) : CW'(CLK_DIV);
            end
            default: ;
        endcase
    end

    spi_clk_div #(.W(CW)) u_div (
        .clk        (in_clock),
        .rst_n      (reset_n),
        .load_i     (div_load),
        .load_val_i (div_val),
        .done_o     (div_done)
    );

    // Transfer FSM; every output is a flop set on the edge entering its state.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b1;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            rx_data_q   <= '0;
            load_data_q <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_ready_q <= 1'b1;
                    if (bus.tx_valid && tx_ready_q) begin
                        load_data_q <= bus.tx_data;
                        tx_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        start_q     <= 1'b0;
                        cs_n_q      <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    start_q <= 1'b1;
                    state_q <= SETUP;
                end
                SETUP: begin
                    if (div_done) begin
                        sclk_q  <= 1'b1;
                        state_q <= SCLK_HI;
                    end
                end
                SCLK_HI: begin
                    if (div_done) begin
                        sclk_q  <= 1'b0;
                        state_q <= SCLK_LO;
                    end
                end
                SCLK_LO: begin
                    if (div_done) begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BW'(SPI_BITS - 1)) begin
                            state_q <= HOLD;
                        end else begin
                            sclk_q  <= 1'b1;
                            state_q <= SCLK_HI;
                        end
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        rx_data_q  <= bus.shift_data;
                        rx_valid_q <= 1'b1;
                        cs_n_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    busy_q     <= 1'b0;
                    tx_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready  = tx_ready_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.busy      = busy_q;
    assign bus.start     = start_q;
    assign bus.load_data = load_data_q;
    assign bus.sclk      = sclk_q;
    assign bus.cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: default-parameter instance with a
// shift-register slave model and scoreboard, plus a fastest-timing instance.
module tb_spi_xfer_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    // DONE is the last cycle of a transfer counted from the accept cycle (cycle 1),
    // so rx_valid is seen this many cycles after the accept sample.
    localparam int LAT = (1 + 1 + CS_SETUP + 16 * CLK_DIV + CS_HOLD + 1) - 1;

    typedef struct {
        logic [7:0] rx;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if a ();
    spi_xfer_ctrl_if b ();

    spi_xfer_ctrl #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) u_dut (
        .in_clock (clk),
        .reset_n  (rst_n),
        .bus      (a.slave)
    );

    spi_xfer_ctrl #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut2 (
        .in_clock (clk),
        .reset_n  (rst_n),
        .bus      (b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    exp_t       sb[$];
    int         cyc = 0;
    int         rise_cnt = 0;
    int         rx_cnt = 0;
    int         hi_len = 0;
    int         lo_len = 0;
    int         chk_ld = 0;
    int         sh_k = 0;
    logic       prev_sclk = 1'b0;
    logic [7:0] exp_ld = 8'h00;
    logic [7:0] miso_next = 8'h00;
    logic [7:0] miso_acc = 8'h00;
    logic [7:0] miso_cur = 8'h00;
    logic [7:0] sr = 8'h00;

    assign a.shift_data = sr;
    assign b.shift_data = 8'h4E;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave shift-register model and protocol monitor for the default instance.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rise_cnt  = 0;
            chk_ld    = 0;
            hi_len    = 0;
            lo_len    = 0;
            prev_sclk = 1'b0;
        end else begin
            if (chk_ld == 2) begin
                chk("start_release", a.start, 1'b1);
                chk_ld = 0;
            end
            if (chk_ld == 1) begin
                chk("load_strobe", {a.start, a.cs_n, a.busy, a.load_data}, {3'b001, exp_ld});
                chk_ld = 2;
            end
            if (!a.start) begin
                sr       = a.load_data;
                miso_cur = miso_acc;
                sh_k     = 0;
            end
            if (a.sclk && !prev_sclk) begin
                if (rise_cnt > 0) chk("sclk_lo_len", lo_len, CLK_DIV);
                rise_cnt++;
                hi_len = 1;
                if (sh_k < 8) begin
                    sr = {sr[6:0], miso_cur[7 - sh_k]};
                    sh_k++;
                end
            end else if (!a.sclk && prev_sclk) begin
                chk("sclk_hi_len", hi_len, CLK_DIV);
                lo_len = 1;
            end else if (a.sclk) begin
                hi_len++;
            end else begin
                lo_len++;
            end
            if (a.busy) chk("ready_while_busy", a.tx_ready, 1'b0);
            if (a.rx_valid) begin
                if (sb.size() == 0) begin
                    chk("rx_unexpected", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rx_data", a.rx_data, e.rx);
                    chk("rx_latency", cyc - e.cyc, LAT);
                    chk("sclk_rises", rise_cnt, 8);
                    chk("cs_n_done", a.cs_n, 1'b1);
                end
                rx_cnt++;
            end
            if (a.tx_valid && a.tx_ready) begin
                chk("accept_after_done", sb.size(), 0);
                chk("accept_cs_high", a.cs_n, 1'b1);
                sb.push_back('{rx: miso_next, cyc: cyc});
                miso_acc = miso_next;
                exp_ld   = a.tx_data;
                chk_ld   = 1;
                rise_cnt = 0;
            end
            prev_sclk = a.sclk;
        end
    end

    // Offer a byte with the given slave response; optionally keep tx_valid high.
    task automatic send(input logic [7:0] d, input logic [7:0] m, input bit hold);
        int k;
        @(posedge clk); #1;
        a.tx_data = d;
        miso_next = m;
        a.tx_valid = 1'b1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (a.tx_ready) break;
            k++;
        end
        chk("send_accept", a.tx_ready, 1'b1);
        @(posedge clk); #1;
        if (!hold) a.tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int target, input string tag);
        int k;
        k = 0;
        while (rx_cnt < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk(tag, rx_cnt, target);
    endtask

    initial begin
        int         rx0;
        int         k;
        int         rxk;
        int         nrx;
        logic [7:0] rxd;
        logic [24:0] pat;
        logic [24:0] pexp;

        rst_n      = 1'b0;
        a.tx_valid = 1'b0;
        a.tx_data  = 8'h00;
        b.tx_valid = 1'b0;
        b.tx_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {a.cs_n, a.sclk, a.start, a.tx_ready, a.rx_valid, a.busy}, 6'b101000);
        chk("rst_data", {a.load_data, a.rx_data}, 16'h0000);
        chk("rst_ctrl2", {b.cs_n, b.sclk, b.start, b.tx_ready, b.rx_valid, b.busy}, 6'b101000);
        #1 rst_n = 1'b1;

        // Idle with tx_valid low: outputs static
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", {a.cs_n, a.sclk, a.start, a.tx_ready, a.rx_valid, a.busy}, 6'b101100);
        end

        // Single transfer, default timing
        send(8'hA5, 8'h3C, 1'b0);
        wait_rx(1, "single_rx");
        chk("rx_hold", a.rx_data, 8'h3C);

        // Fastest timing on the second instance
        @(posedge clk); #1;
        b.tx_data  = 8'h99;
        b.tx_valid = 1'b1;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (b.tx_ready) break;
            k++;
        end
        chk("d2_accept", b.tx_ready, 1'b1);
        pat = '0;
        pexp = '0;
        rxk = 0;
        nrx = 0;
        rxd = 8'h00;
        for (int j = 1; j < 25; j++) begin
            @(posedge clk); #1;
            if (j == 1) b.tx_valid = 1'b0;
            @(negedge clk);
            pat[j] = b.sclk;
            pexp[j] = (j >= 3 && j <= 18 && ((j - 3) % 2 == 0));
            if (b.rx_valid) begin
                rxk = j;
                rxd = b.rx_data;
                nrx++;
            end
        end
        chk("d2_sclk_pattern", pat, pexp);
        chk("d2_latency", rxk, 20);
        chk("d2_rx_data", rxd, 8'h4E);
        chk("d2_rx_pulses", nrx, 1);

        // Back-to-back with tx_valid held high
        rx0 = rx_cnt;
        send(8'h01, 8'hC3, 1'b1);
        send(8'hFE, 8'h96, 1'b0);
        wait_rx(rx0 + 2, "b2b_rx");

        // Reset during the third SCLK high phase
        send(8'h77, 8'h11, 1'b0);
        k = 0;
        while (rise_cnt < 3 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("abort_reach_rise3", rise_cnt, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_outs", {a.cs_n, a.sclk, a.busy, a.start, a.tx_ready, a.rx_valid}, 6'b100100);
        sb.delete();
        rx0 = rx_cnt;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("abort_no_rx", rx_cnt, rx0);
        send(8'h5A, 8'hA5, 1'b0);
        wait_rx(rx0 + 1, "after_abort_rx");

        // tx_valid/tx_data wiggling during a transfer
        rx0 = rx_cnt;
        send(8'h3A, 8'h5C, 1'b0);
        for (int j = 0; j < 30; j++) begin
            @(posedge clk); #1;
            a.tx_valid = 1'($urandom_range(0, 1));
            a.tx_data  = 8'($urandom);
            @(negedge clk);
            chk("load_stable", a.load_data, 8'h3A);
            chk("ready_mid", a.tx_ready, 1'b0);
        end
        @(posedge clk); #1;
        a.tx_valid = 1'b0;
        wait_rx(rx0 + 1, "wiggle_rx");
        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
